// File: rtl/pipe_stage_buf_pkg.sv
// Shared definitions for the inter-stage pipeline buffer: occupancy states,
// control-bundle bit positions and the NOP bundle presented on bubbles.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_t;

    localparam int unsigned CTRL_W_DEF   = 11;
    localparam int unsigned CTRL_RW      = 0;
    localparam int unsigned CTRL_E       = 1;
    localparam int unsigned CTRL_SIZE_LO = 2;
    localparam int unsigned CTRL_SIZE_HI = 3;
    localparam int unsigned CTRL_RFLE    = 4;
    localparam int unsigned CTRL_L       = 5;

    localparam logic [CTRL_W_DEF-1:0] NOP_CTRL = '0;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready stream carrying one control bundle, destination register and data word.
interface pipe_stage_buf_if #(
    parameter int unsigned CTRL_W = 11,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;

    modport master (output valid, ctrl, rd, data, input ready);
    modport slave  (input valid, ctrl, rd, data, output ready);
endinterface

// File: rtl/pipe_stage_buf_entry.sv
// One buffer slot: valid flag plus ctrl/rd/data registers; clear wins over load.
module pipe_entry #(
    parameter int unsigned CTRL_W = 11,
    parameter int unsigned RD_W   = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [RD_W-1:0]   d_rd,
    input  logic [DATA_W-1:0] d_data,
    output logic              valid,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [RD_W-1:0]   q_rd,
    output logic [DATA_W-1:0] q_data
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid  <= 1'b0;
            q_ctrl <= '0;
            q_rd   <= '0;
            q_data <= '0;
        end else if (clear) begin
            valid  <= 1'b0;
            q_ctrl <= '0;
            q_rd   <= '0;
            q_data <= '0;
        end else if (load) begin
            valid  <= 1'b1;
            q_ctrl <= d_ctrl;
            q_rd   <= d_rd;
            q_data <= d_data;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer: head + optional skid slot behind a valid/ready
// handshake, with flush, NOP bubbles, a forwarding tap and a saturating stall counter.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W   = 11,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RD_W     = 5,
    parameter int unsigned RFLE_BIT = CTRL_RFLE,
    parameter int unsigned SKID     = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    pipe_stage_buf_if.slave  up,
    pipe_stage_buf_if.master dn,
    output logic             fwd_we,
    output logic [RD_W-1:0]  fwd_rd,
    output logic [CNT_W-1:0] stall_cnt
);

    buf_state_t state, state_nxt;

    logic              head_valid, skid_valid;
    logic [CTRL_W-1:0] head_ctrl, skid_ctrl, head_d_ctrl;
    logic [RD_W-1:0]   head_rd, skid_rd, head_d_rd, out_rd;
    logic [DATA_W-1:0] head_data, skid_data, head_d_data;
    logic              head_load, head_clr, head_from_skid;
    logic              skid_load, skid_clr;
    logic              in_ready, xfer_in, xfer_out;

    // With a skid slot, in_ready comes straight from a register; without one it
    // must look at out_ready to keep full throughput through the single slot.
    assign in_ready = (SKID != 0) ? ~skid_valid : (~head_valid | dn.ready);
    assign up.ready = in_ready;
    assign xfer_in  = up.valid & in_ready;
    assign xfer_out = head_valid & dn.ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        head_load      = 1'b0;
        head_clr       = 1'b0;
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            head_clr  = 1'b1;
            skid_clr  = 1'b1;
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (xfer_in) begin
                        head_load = 1'b1;
                        state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (xfer_in && !xfer_out) begin
                        skid_load = 1'b1;
                        state_nxt = ST_TWO;
                    end else if (xfer_in) begin
                        head_load = 1'b1;
                    end else if (xfer_out) begin
                        head_clr  = 1'b1;
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (xfer_out) begin
                        head_load      = 1'b1;
                        head_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                        state_nxt      = ST_ONE;
                    end
                end
                default: state_nxt = ST_EMPTY;
            endcase
        end
    end

    assign head_d_ctrl = head_from_skid ? skid_ctrl : up.ctrl;
    assign head_d_rd   = head_from_skid ? skid_rd   : up.rd;
    assign head_d_data = head_from_skid ? skid_data : up.data;

    pipe_entry #(.CTRL_W(CTRL_W), .RD_W(RD_W), .DATA_W(DATA_W)) u_head (
        .clk    (clk),
        .reset  (reset),
        .load   (head_load),
        .clear  (head_clr),
        .d_ctrl (head_d_ctrl),
        .d_rd   (head_d_rd),
        .d_data (head_d_data),
        .valid  (head_valid),
        .q_ctrl (head_ctrl),
        .q_rd   (head_rd),
        .q_data (head_data)
    );

    pipe_entry #(.CTRL_W(CTRL_W), .RD_W(RD_W), .DATA_W(DATA_W)) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load   (skid_load),
        .clear  (skid_clr),
        .d_ctrl (up.ctrl),
        .d_rd   (up.rd),
        .d_data (up.data),
        .valid  (skid_valid),
        .q_ctrl (skid_ctrl),
        .q_rd   (skid_rd),
        .q_data (skid_data)
    );

    // An invalid head shows the NOP bundle so downstream sees no RF write or memory enable.
    assign out_rd   = head_valid ? head_rd : '0;
    assign dn.valid = head_valid;
    assign dn.ctrl  = head_valid ? head_ctrl : CTRL_W'(NOP_CTRL);
    assign dn.rd    = out_rd;
    assign dn.data  = head_data;
    assign fwd_we   = head_valid & head_ctrl[RFLE_BIT];
    assign fwd_rd   = out_rd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (head_valid && !dn.ready && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: SKID=1 and SKID=0 instances against a bounded-FIFO
// reference model, plus a directed vector table and hand-written corner sequences.
module tb_pipe_stage_buf;

    localparam int unsigned CNT_W     = 4;
    localparam int unsigned STALL_MAX = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, out_ready, flush;
    logic [10:0] in_ctrl;
    logic [4:0]  in_rd;
    logic [31:0] in_data;

    always #5 clk = ~clk;

    pipe_stage_buf_if #(.CTRL_W(11), .RD_W(5), .DATA_W(32)) u_up1 ();
    pipe_stage_buf_if #(.CTRL_W(11), .RD_W(5), .DATA_W(32)) u_dn1 ();
    pipe_stage_buf_if #(.CTRL_W(11), .RD_W(5), .DATA_W(32)) u_up0 ();
    pipe_stage_buf_if #(.CTRL_W(11), .RD_W(5), .DATA_W(32)) u_dn0 ();

    logic [1:0]  o_valid, i_ready, f_we;
    logic [10:0] o_ctrl [2];
    logic [4:0]  o_rd   [2];
    logic [4:0]  f_rd   [2];
    logic [31:0] o_data [2];
    logic [CNT_W-1:0] s_cnt [2];

    assign u_up1.valid = in_valid;
    assign u_up1.ctrl  = in_ctrl;
    assign u_up1.rd    = in_rd;
    assign u_up1.data  = in_data;
    assign u_dn1.ready = out_ready;
    assign u_up0.valid = in_valid;
    assign u_up0.ctrl  = in_ctrl;
    assign u_up0.rd    = in_rd;
    assign u_up0.data  = in_data;
    assign u_dn0.ready = out_ready;

    pipe_stage_buf #(.CTRL_W(11), .DATA_W(32), .RD_W(5), .RFLE_BIT(4), .SKID(1), .CNT_W(CNT_W)) dut1 (
        .clk(clk), .reset(reset), .flush(flush), .up(u_up1), .dn(u_dn1),
        .fwd_we(f_we[1]), .fwd_rd(f_rd[1]), .stall_cnt(s_cnt[1])
    );
    pipe_stage_buf #(.CTRL_W(11), .DATA_W(32), .RD_W(5), .RFLE_BIT(4), .SKID(0), .CNT_W(CNT_W)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .up(u_up0), .dn(u_dn0),
        .fwd_we(f_we[0]), .fwd_rd(f_rd[0]), .stall_cnt(s_cnt[0])
    );

    assign o_valid[1] = u_dn1.valid;
    assign o_ctrl[1]  = u_dn1.ctrl;
    assign o_rd[1]    = u_dn1.rd;
    assign o_data[1]  = u_dn1.data;
    assign i_ready[1] = u_up1.ready;
    assign o_valid[0] = u_dn0.valid;
    assign o_ctrl[0]  = u_dn0.ctrl;
    assign o_rd[0]    = u_dn0.rd;
    assign o_data[0]  = u_dn0.data;
    assign i_ready[0] = u_up0.ready;

    int unsigned tests = 0;
    int unsigned fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: a FIFO of capacity 2 (skid) or 1 (single), head = oldest.
    typedef struct packed {
        logic [10:0] c;
        logic [4:0]  r;
        logic [31:0] d;
    } bnd_t;

    bnd_t        mq     [2][2];
    int unsigned mcnt   [2];
    int unsigned mstall [2];

    function automatic logic m_in_ready(input int k);
        if (k == 1) return mcnt[1] < 2;
        return (mcnt[0] == 0) || out_ready;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mcnt[k]   = 0;
            mstall[k] = 0;
        end
    endtask

    task automatic model_advance();
        for (int k = 0; k < 2; k++) begin
            logic ir, ov;
            ir = m_in_ready(k);
            ov = (mcnt[k] != 0);
            if (ov && !out_ready && mstall[k] < STALL_MAX) mstall[k]++;
            if (flush) begin
                mcnt[k] = 0;
            end else begin
                if (ov && out_ready) begin
                    mq[k][0] = mq[k][1];
                    mcnt[k]--;
                end
                if (in_valid && ir) begin
                    mq[k][mcnt[k]] = '{in_ctrl, in_rd, in_data};
                    mcnt[k]++;
                end
            end
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 2; k++) begin
            bnd_t h;
            logic v;
            h = mq[k][0];
            v = (mcnt[k] != 0);
            chk($sformatf("d%0d.out_valid", k), o_valid[k], v);
            chk($sformatf("d%0d.in_ready", k), i_ready[k], m_in_ready(k));
            chk($sformatf("d%0d.out_ctrl", k), o_ctrl[k], v ? h.c : 11'd0);
            chk($sformatf("d%0d.out_rd", k), o_rd[k], v ? h.r : 5'd0);
            if (v) chk($sformatf("d%0d.out_data", k), o_data[k], h.d);
            chk($sformatf("d%0d.fwd_we", k), f_we[k], v & h.c[4]);
            chk($sformatf("d%0d.fwd_rd", k), f_rd[k], v ? h.r : 5'd0);
            chk($sformatf("d%0d.stall_cnt", k), s_cnt[k], mstall[k]);
        end
    endtask

    task automatic step(input logic iv, input logic [10:0] c, input logic [4:0] r,
                        input logic [31:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_ctrl   = c;
        in_rd     = r;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        model_advance();
        @(posedge clk);
        #1;
        check_model();
    endtask

    typedef struct {
        logic        iv;
        logic [10:0] c;
        logic [4:0]  r;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        ev;
        logic [31:0] ed;
        logic        eir;
        logic [3:0]  es;
        logic        ew;
        logic [4:0]  erd;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic iv, input logic [10:0] c, input logic [4:0] r,
                        input logic [31:0] d, input logic ordy, input logic fl,
                        input logic ev, input logic [31:0] ed, input logic eir,
                        input logic [3:0] es, input logic ew, input logic [4:0] erd);
        vec_t v;
        v = '{iv, c, r, d, ordy, fl, ev, ed, eir, es, ew, erd};
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        in_ctrl = '0; in_rd = '0; in_data = '0;
        model_reset();
        #12;
        chk("rst.out_valid", o_valid[1], 1'b0);
        chk("rst.in_ready", i_ready[1], 1'b1);
        chk("rst.stall_cnt", s_cnt[1], 0);
        check_model();
        reset = 1'b1;

        // streaming 1..8, then drain
        for (int unsigned i = 1; i <= 8; i++) addv(1, 0, 0, i, 1, 0, 1, i, 1, 0, 0, 0);
        addv(0, 0, 0, 0,     1, 0,  0, 0,     1, 0, 0, 0);
        // back-pressure A,B,C
        addv(1, 0, 0, 'hA,   0, 0,  1, 'hA,   1, 0, 0, 0);
        addv(1, 0, 0, 'hB,   0, 0,  1, 'hA,   0, 1, 0, 0);
        addv(1, 0, 0, 'hC,   0, 0,  1, 'hA,   0, 2, 0, 0);
        addv(1, 0, 0, 'hC,   1, 0,  1, 'hB,   1, 2, 0, 0);
        addv(1, 0, 0, 'hC,   1, 0,  1, 'hC,   1, 2, 0, 0);
        addv(0, 0, 0, 0,     1, 0,  0, 0,     1, 2, 0, 0);
        // flush from TWO with a pending input
        addv(1, 0, 0, 'hD,   0, 0,  1, 'hD,   1, 2, 0, 0);
        addv(1, 0, 0, 'hE,   0, 0,  1, 'hD,   0, 3, 0, 0);
        addv(1, 0, 0, 'hF,   0, 1,  0, 0,     1, 4, 0, 0);
        addv(0, 0, 0, 0,     0, 0,  0, 0,     1, 4, 0, 0);
        // flush from ONE drops an accepted-looking input
        addv(1, 0, 0, 'h11,  0, 0,  1, 'h11,  1, 4, 0, 0);
        addv(1, 0, 0, 'h12,  0, 1,  0, 0,     1, 5, 0, 0);
        addv(0, 0, 0, 0,     1, 0,  0, 0,     1, 5, 0, 0);
        // forwarding tap
        addv(1, 'h010, 7, 'h77, 1, 0, 1, 'h77, 1, 5, 1, 7);
        addv(1, 'h000, 7, 'h78, 1, 0, 1, 'h78, 1, 5, 0, 7);
        addv(0, 0, 0, 0,     1, 0,  0, 0,     1, 5, 0, 0);

        foreach (vecs[i]) begin
            step(vecs[i].iv, vecs[i].c, vecs[i].r, vecs[i].d, vecs[i].ordy, vecs[i].fl);
            chk($sformatf("vec%0d.out_valid", i), o_valid[1], vecs[i].ev);
            if (vecs[i].ev) chk($sformatf("vec%0d.out_data", i), o_data[1], vecs[i].ed);
            chk($sformatf("vec%0d.in_ready", i), i_ready[1], vecs[i].eir);
            chk($sformatf("vec%0d.stall_cnt", i), s_cnt[1], vecs[i].es);
            chk($sformatf("vec%0d.fwd_we", i), f_we[1], vecs[i].ew);
            chk($sformatf("vec%0d.fwd_rd", i), f_rd[1], vecs[i].erd);
        end

        // stall counter saturation, and flush leaves it alone
        step(1, 'h010, 9, 'h5A, 0, 0);
        for (int unsigned i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0);
        chk("sat.stall_cnt", s_cnt[1], 15);
        for (int unsigned i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0);
        chk("sat.hold", s_cnt[1], 15);
        step(0, 0, 0, 0, 0, 1);
        chk("sat.after_flush", s_cnt[1], 15);

        // asynchronous reset while two entries are held
        step(1, 'h7FF, 3, 'hA1, 0, 0);
        step(1, 'h7FF, 4, 'hA2, 0, 0);
        chk("two.in_ready", i_ready[1], 1'b0);
        chk("two.out_ctrl", o_ctrl[1], 'h7FF);
        #2;
        reset = 1'b0;
        #1;
        chk("arst.out_valid", o_valid[1], 1'b0);
        chk("arst.out_ctrl", o_ctrl[1], 0);
        chk("arst.in_ready", i_ready[1], 1'b1);
        chk("arst.stall_cnt", s_cnt[1], 0);
        chk("arst.fwd_we", f_we[1], 1'b0);
        model_reset();
        check_model();
        #1;
        reset = 1'b1;

        for (int unsigned i = 0; i < 500; i++) begin
            step($urandom_range(0, 3) != 0, 11'($urandom), 5'($urandom), $urandom,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
